// File: rtl/mdu_pkg.sv
// mdu_pkg
// Shared definitions for the multiply/divide sequencer:
//   mdu_op_t    - operation encoding carried on the op bus
//   mdu_state_t - sequencer state encoding
//   ALU_ADD / ALU_SUB - ALU control codes driven while the block owns the ALU
package mdu_pkg;

   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_DIVU  = 2'b01,
      OP_MULT  = 2'b10,
      OP_DIV   = 2'b11
   } mdu_op_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_MUL   = 3'd1,
      ST_DIV   = 3'd2,
      ST_FIXUP = 3'd3,
      ST_DONE  = 3'd4
   } mdu_state_t;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;

endpackage

// File: rtl/mdu_sequencer_if.sv
// mdu_sequencer_if
// Bundles the request/result handshake and the borrowed-ALU bus of the
// multiply/divide sequencer.
//   master modport : pipeline side (drives start/op/src_*, returns alu_result)
//   slave modport  : the sequencer itself
// Signals:
//   start, op, src_a, src_b      - request and operands
//   alu_req, alu_a, alu_b,
//   alu_control, alu_result      - shared ALU borrow path
//   busy, done, hi, lo           - stall request and results
interface mdu_sequencer_if #(
   parameter int XLEN = 32
);

   logic            start;
   logic [1:0]      op;
   logic [XLEN-1:0] src_a;
   logic [XLEN-1:0] src_b;
   logic            alu_req;
   logic [XLEN-1:0] alu_a;
   logic [XLEN-1:0] alu_b;
   logic [2:0]      alu_control;
   logic [XLEN-1:0] alu_result;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;

   modport master (
      output start, op, src_a, src_b, alu_result,
      input  alu_req, alu_a, alu_b, alu_control, busy, done, hi, lo
   );

   modport slave (
      input  start, op, src_a, src_b, alu_result,
      output alu_req, alu_a, alu_b, alu_control, busy, done, hi, lo
   );

endinterface

// File: rtl/mdu_sequencer.sv
// mdu_sequencer
// Multi-cycle multiply/divide controller. It borrows the shared EX-stage ALU
// for one add (multiply) or subtract (divide) per cycle and runs XLEN
// iterations to build HI/LO. While it owns the ALU the pipeline is stalled
// through busy.
// Ports:
//   clk      - clock, rising edge
//   reset_n  - asynchronous active-low reset; aborts any operation
//   bus      - mdu_sequencer_if.slave (start/op/src_a/src_b in,
//              alu_req/alu_a/alu_b/alu_control out, alu_result in,
//              busy/done/hi/lo out)
// Optional feature macro: MDU_SIGNED_EN
//   defined   - op[1] selects signed MULT/DIV with a one-cycle FIXUP state
//   undefined - op[1] ignored, all operations unsigned, no FIXUP logic
module mdu_sequencer
   import mdu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input logic          clk,
   input logic          reset_n,
   mdu_sequencer_if.slave bus
);

   localparam int CW = $clog2(XLEN);

   mdu_state_t      state;
   logic [XLEN-1:0] hi_q;
   logic [XLEN-1:0] lo_q;
   logic [XLEN-1:0] opnd;
   logic [CW-1:0]   cnt;

   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag;
   logic            carry;
   logic [XLEN-1:0] div_r;
   logic            div_ge;
   logic            last_iter;

`ifdef MDU_SIGNED_EN
   logic            sign_a;
   logic            sign_b;
   logic            is_signed;
   logic            is_div;
   logic            neg_lo;
   logic            neg_hi;
   logic [2*XLEN-1:0] prod_neg;
`else
   logic            unused_op1;
   assign unused_op1 = bus.op[1];
`endif

   // Operand magnitudes captured at start. Signed requests are folded to
   // unsigned magnitudes so the iteration datapath only ever sees unsigned
   // values; the signs are reapplied in FIXUP.
   always_comb begin
      a_mag = bus.src_a;
      b_mag = bus.src_b;
`ifdef MDU_SIGNED_EN
      sign_a = 1'b0;
      sign_b = 1'b0;
      if (bus.op[1]) begin
         sign_a = bus.src_a[XLEN-1];
         sign_b = bus.src_b[XLEN-1];
         if (sign_a) a_mag = -bus.src_a;
         if (sign_b) b_mag = -bus.src_b;
      end
`endif
   end

   // Per-iteration helpers. The multiply carry falls out of an unsigned
   // compare because the ALU gives no carry-out. For the restoring divide
   // the shifted-out top bit of hi (div_c) means the partial remainder is
   // already at least 2^XLEN and therefore exceeds any divisor.
   always_comb begin
      carry     = (bus.alu_result < hi_q);
      div_r     = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
      div_ge    = hi_q[XLEN-1] || (div_r >= opnd);
      last_iter = (cnt == CW'(XLEN - 1));
   end

`ifdef MDU_SIGNED_EN
   assign prod_neg = -{hi_q, lo_q};
`endif

   // ALU borrow: only MUL and DIV drive the shared ALU; elsewhere the
   // outputs rest at zero operands with an add so the EX mux sees a benign
   // value even if it were selected.
   always_comb begin
      bus.alu_req     = 1'b0;
      bus.alu_a       = '0;
      bus.alu_b       = '0;
      bus.alu_control = ALU_ADD;
      case (state)
         ST_MUL: begin
            bus.alu_req = 1'b1;
            bus.alu_a   = hi_q;
            bus.alu_b   = opnd;
         end
         ST_DIV: begin
            bus.alu_req     = 1'b1;
            bus.alu_a       = div_r;
            bus.alu_b       = opnd;
            bus.alu_control = ALU_SUB;
         end
         default: ;
      endcase
   end

   assign bus.busy = (state == ST_MUL) || (state == ST_DIV) || (state == ST_FIXUP);
   assign bus.done = (state == ST_DONE);
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

   // Sequencer. A start is only honoured in IDLE or DONE, so a request
   // arriving mid-operation is dropped rather than queued. Divide by zero
   // is resolved at start and jumps straight to DONE with the raw dividend
   // in hi and all ones in lo.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         hi_q  <= '0;
         lo_q  <= '0;
         opnd  <= '0;
         cnt   <= '0;
`ifdef MDU_SIGNED_EN
         is_signed <= 1'b0;
         is_div    <= 1'b0;
         neg_lo    <= 1'b0;
         neg_hi    <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  cnt <= '0;
`ifdef MDU_SIGNED_EN
                  is_signed <= bus.op[1];
                  is_div    <= bus.op[0];
                  neg_lo    <= sign_a ^ sign_b;
                  neg_hi    <= bus.op[0] ? sign_a : (sign_a ^ sign_b);
`endif
                  if (bus.op[0] && (bus.src_b == '0)) begin
                     hi_q  <= bus.src_a;
                     lo_q  <= '1;
                     state <= ST_DONE;
                  end else if (bus.op[0]) begin
                     hi_q  <= '0;
                     lo_q  <= a_mag;
                     opnd  <= b_mag;
                     state <= ST_DIV;
                  end else begin
                     hi_q  <= '0;
                     lo_q  <= b_mag;
                     opnd  <= a_mag;
                     state <= ST_MUL;
                  end
               end else begin
                  state <= ST_IDLE;
               end
            end

            ST_MUL, ST_DIV: begin
               if (state == ST_MUL) begin
                  if (lo_q[0]) begin
                     {hi_q, lo_q} <= {carry, bus.alu_result, lo_q[XLEN-1:1]};
                  end else begin
                     {hi_q, lo_q} <= {1'b0, hi_q, lo_q[XLEN-1:1]};
                  end
               end else begin
                  hi_q <= div_ge ? bus.alu_result : div_r;
                  lo_q <= {lo_q[XLEN-2:0], div_ge};
               end
               cnt <= cnt + 1'b1;
               if (last_iter) begin
`ifdef MDU_SIGNED_EN
                  state <= is_signed ? ST_FIXUP : ST_DONE;
`else
                  state <= ST_DONE;
`endif
               end
            end

`ifdef MDU_SIGNED_EN
            // Reapply signs: the product is negated as one 2*XLEN value,
            // the quotient follows the sign product and the remainder
            // follows the dividend.
            ST_FIXUP: begin
               if (!is_div) begin
                  if (neg_lo) {hi_q, lo_q} <= prod_neg;
               end else begin
                  if (neg_lo) lo_q <= -lo_q;
                  if (neg_hi) hi_q <= -hi_q;
               end
               state <= ST_DONE;
            end
`endif

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer
// Self-checking bench for mdu_sequencer: a table of directed operations with
// hand-computed results and latencies, plus hand-written sequences for the
// ignored mid-operation start, the start-in-DONE restart and the mid-divide
// reset. The shared ALU is modelled here as a plain add/sub.
module tb_mdu_sequencer;
   import mdu_pkg::*;

   logic clk;
   logic reset_n;

   mdu_sequencer_if #(.XLEN(32)) ifc ();

   mdu_sequencer #(.XLEN(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (ifc.slave)
   );

   // Shared EX-stage ALU model
   assign ifc.alu_result = (ifc.alu_control == ALU_SUB) ? (ifc.alu_a - ifc.alu_b)
                                                        : (ifc.alu_a + ifc.alu_b);

   // Free-running clock, 10 time units per cycle
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      int          exp_cyc;
      int          exp_req;
      logic [2:0]  exp_ctl;
   } vec_t;

   vec_t vecs[$];
   int   total_checks;
   int   pass_checks;

   int   done_cyc;
   int   req_cnt;
   int   busy_cnt;
   int   bad_cnt;

   function automatic vec_t mk(logic [1:0] op, logic [31:0] a, logic [31:0] b,
                               logic [31:0] eh, logic [31:0] el, int cyc, int req);
      vec_t v;
      v.op      = op;
      v.a       = a;
      v.b       = b;
      v.exp_hi  = eh;
      v.exp_lo  = el;
      v.exp_cyc = cyc;
      v.exp_req = req;
      v.exp_ctl = op[0] ? ALU_SUB : ALU_ADD;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_checks++;
      if (act === exp) begin
         pass_checks++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Presents one request for one clock; returns at the negedge of cycle 1
   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      ifc.start = 1'b1;
      ifc.op    = op;
      ifc.src_a = a;
      ifc.src_b = b;
      @(negedge clk);
      ifc.start = 1'b0;
   endtask

   // Watches cycles 1..limit until done, counting ALU ownership, busy and
   // ALU-bus violations; optionally pulses a stray start at inj_cyc.
   task automatic waitDone(input int limit, input logic [2:0] exp_ctl, input int inj_cyc,
                           input logic [1:0] inj_op, input logic [31:0] inj_a, input logic [31:0] inj_b,
                           output int d_cyc, output int r_cnt, output int b_cnt, output int bad);
      d_cyc = 0;
      r_cnt = 0;
      b_cnt = 0;
      bad   = 0;
      for (int c = 1; c <= limit; c++) begin
         if (c == inj_cyc) begin
            ifc.start = 1'b1;
            ifc.op    = inj_op;
            ifc.src_a = inj_a;
            ifc.src_b = inj_b;
         end else begin
            ifc.start = 1'b0;
         end
         if (ifc.alu_req) begin
            r_cnt++;
            if (ifc.alu_control !== exp_ctl) bad++;
         end else if (ifc.alu_a !== 32'd0 || ifc.alu_b !== 32'd0 || ifc.alu_control !== ALU_ADD) begin
            bad++;
         end
         if (ifc.busy) b_cnt++;
         if (ifc.done) begin
            d_cyc = c;
            break;
         end
         @(negedge clk);
      end
      ifc.start = 1'b0;
   endtask

   initial begin
      total_checks = 0;
      pass_checks  = 0;
      reset_n      = 1'b0;
      ifc.start    = 1'b0;
      ifc.op       = 2'b00;
      ifc.src_a    = '0;
      ifc.src_b    = '0;

      vecs.push_back(mk(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 32));
      vecs.push_back(mk(OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       33, 32));
      vecs.push_back(mk(OP_DIVU,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1,  0));
      vecs.push_back(mk(OP_MULTU, 32'd3,        32'd5,        32'd0,        32'd15,       33, 32));
      vecs.push_back(mk(OP_MULTU, 32'h12345678, 32'h00000100, 32'h00000012, 32'h34567800, 33, 32));
      vecs.push_back(mk(OP_MULTU, 32'd0,        32'hDEADBEEF, 32'd0,        32'd0,        33, 32));
      vecs.push_back(mk(OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 33, 32));
      vecs.push_back(mk(OP_DIVU,  32'd5,        32'd10,       32'd5,        32'd0,        33, 32));
      vecs.push_back(mk(OP_DIVU,  32'h80000000, 32'd3,        32'd2,        32'h2AAAAAAA, 33, 32));
`ifdef MDU_SIGNED_EN
      vecs.push_back(mk(OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 34, 32));
      vecs.push_back(mk(OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 34, 32));
      vecs.push_back(mk(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 34, 32));
`else
      vecs.push_back(mk(OP_MULT,  32'hFFFFFFFD, 32'd5,        32'h00000004, 32'hFFFFFFF1, 33, 32));
      vecs.push_back(mk(OP_DIV,   32'd100,      32'd7,        32'd2,        32'd14,       33, 32));
`endif

      // Reset state
      repeat (2) @(negedge clk);
      checkOutput("reset_hi",      {32'd0, ifc.hi}, 64'd0);
      checkOutput("reset_lo",      {32'd0, ifc.lo}, 64'd0);
      checkOutput("reset_busy",    {63'd0, ifc.busy}, 64'd0);
      checkOutput("reset_done",    {63'd0, ifc.done}, 64'd0);
      checkOutput("reset_alu_req", {63'd0, ifc.alu_req}, 64'd0);
      checkOutput("reset_alu_a",   {32'd0, ifc.alu_a}, 64'd0);
      checkOutput("reset_alu_b",   {32'd0, ifc.alu_b}, 64'd0);
      checkOutput("reset_alu_ctl", {61'd0, ifc.alu_control}, {61'd0, ALU_ADD});
      reset_n = 1'b1;

      // Directed table
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
         waitDone(60, vecs[i].exp_ctl, 0, 2'b00, 32'd0, 32'd0, done_cyc, req_cnt, busy_cnt, bad_cnt);
         checkOutput($sformatf("v%0d_done_cycle", i), 64'(done_cyc), 64'(vecs[i].exp_cyc));
         checkOutput($sformatf("v%0d_hi", i), {32'd0, ifc.hi}, {32'd0, vecs[i].exp_hi});
         checkOutput($sformatf("v%0d_lo", i), {32'd0, ifc.lo}, {32'd0, vecs[i].exp_lo});
         checkOutput($sformatf("v%0d_alu_req_cycles", i), 64'(req_cnt), 64'(vecs[i].exp_req));
         checkOutput($sformatf("v%0d_busy_cycles", i), 64'(busy_cnt), 64'(vecs[i].exp_cyc - 1));
         checkOutput($sformatf("v%0d_alu_bus_errors", i), 64'(bad_cnt), 64'd0);
         @(negedge clk);
         checkOutput($sformatf("v%0d_done_pulse_end", i), {63'd0, ifc.done}, 64'd0);
         checkOutput($sformatf("v%0d_lo_hold", i), {32'd0, ifc.lo}, {32'd0, vecs[i].exp_lo});
      end

      // Stray start at cycle 10 of MULTU 3x5 must be ignored
      applyStimulus(OP_MULTU, 32'd3, 32'd5);
      waitDone(60, ALU_ADD, 10, OP_MULTU, 32'd7, 32'd7, done_cyc, req_cnt, busy_cnt, bad_cnt);
      checkOutput("ignore_done_cycle", 64'(done_cyc), 64'd33);
      checkOutput("ignore_lo", {32'd0, ifc.lo}, 64'd15);
      checkOutput("ignore_hi", {32'd0, ifc.hi}, 64'd0);

      // Start presented during the DONE cycle is accepted
      ifc.start = 1'b1;
      ifc.op    = OP_MULTU;
      ifc.src_a = 32'd6;
      ifc.src_b = 32'd7;
      @(negedge clk);
      ifc.start = 1'b0;
      checkOutput("restart_busy", {63'd0, ifc.busy}, 64'd1);
      waitDone(60, ALU_ADD, 0, 2'b00, 32'd0, 32'd0, done_cyc, req_cnt, busy_cnt, bad_cnt);
      checkOutput("restart_done_cycle", 64'(done_cyc), 64'd33);
      checkOutput("restart_lo", {32'd0, ifc.lo}, 64'd42);

      // Reset in the middle of a divide
      applyStimulus(OP_DIVU, 32'd100, 32'd7);
      waitDone(14, ALU_SUB, 0, 2'b00, 32'd0, 32'd0, done_cyc, req_cnt, busy_cnt, bad_cnt);
      checkOutput("abort_no_early_done", 64'(done_cyc), 64'd0);
      checkOutput("abort_busy_before", {63'd0, ifc.busy}, 64'd1);
      reset_n = 1'b0;
      #1;
      checkOutput("abort_busy", {63'd0, ifc.busy}, 64'd0);
      checkOutput("abort_alu_req", {63'd0, ifc.alu_req}, 64'd0);
      checkOutput("abort_lo", {32'd0, ifc.lo}, 64'd0);
      checkOutput("abort_hi", {32'd0, ifc.hi}, 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      waitDone(40, ALU_ADD, 0, 2'b00, 32'd0, 32'd0, done_cyc, req_cnt, busy_cnt, bad_cnt);
      checkOutput("abort_no_done", 64'(done_cyc), 64'd0);
      checkOutput("abort_idle_busy", 64'(busy_cnt), 64'd0);
      applyStimulus(OP_MULTU, 32'd2, 32'd2);
      waitDone(60, ALU_ADD, 0, 2'b00, 32'd0, 32'd0, done_cyc, req_cnt, busy_cnt, bad_cnt);
      checkOutput("after_reset_done_cycle", 64'(done_cyc), 64'd33);
      checkOutput("after_reset_lo", {32'd0, ifc.lo}, 64'd4);
      checkOutput("after_reset_hi", {32'd0, ifc.hi}, 64'd0);

      $display("%0d/%0d checks passed", pass_checks, total_checks);
      $finish;
   end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multi-cycle multiply/divide controller that borrows the shared ALU for one add/sub per cycle and sequences 32 iterations to produce HI/LO.
- Sits beside the EX stage. While it holds the ALU, the pipeline stalls and the EX operand mux selects this block's alu_* outputs.
- Supports MULTU/DIVU; MULT/DIV are available when the optional feature is compiled in.

Parameters:
- XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
- clk  in  1  clock; all state updates on its rising edge
- reset_n  in  1  reset, asynchronous, active-low
- start  in  1  request pulse; sampled in IDLE or DONE only
- op  in  2  operation: 00 MULTU, 01 DIVU, 10 MULT, 11 DIV
- src_a  in  XLEN  multiplicand / dividend (rs)
- src_b  in  XLEN  multiplier / divisor (rt)
- alu_req  out  1  block owns the ALU this cycle; the EX mux selects alu_a/alu_b/alu_control
- alu_a  out  XLEN  ALU operand a
- alu_b  out  XLEN  ALU operand b
- alu_control  out  3  ALU op: 3'b010 add, 3'b110 sub
- alu_result  in  XLEN  combinational ALU result, consumed in the same cycle
- busy  out  1  stall request to the hazard unit
- done  out  1  one-cycle pulse; hi/lo valid
- hi  out  XLEN  product high word / remainder
- lo  out  XLEN  product low word / quotient

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; hi=lo=0; busy=done=alu_req=0.
  - alu_a=alu_b=0; alu_control=3'b010.
  - Reset mid-operation aborts immediately; there is no partial result and no done pulse.
- States: IDLE, MUL, DIV, FIXUP, DONE.
- Start acceptance:
  - start in IDLE or DONE loads operands and sets cnt=0.
  - Next state is MUL (op[0]=0) or DIV (op[0]=1).
  - start in MUL/DIV/FIXUP is ignored and does not queue.
- MUL, unsigned shift-add (acc={hi,lo}, lo initialised to the multiplier, hi=0):
  - Drive alu_a=hi, alu_b=multiplicand, alu_control=add.
  - carry = (alu_result < hi), an unsigned compare done locally.
  - If lo[0]=1: {hi,lo} <= {carry, alu_result, lo[XLEN-1:1]}.
  - Otherwise: {hi,lo} <= {1'b0, hi, lo[XLEN-1:1]}.
- DIV, restoring (rem=hi, quotient=lo initialised to the dividend):
  - Shift: {c,r} = {hi,lo[XLEN-1]}, a 33-bit value.
  - Drive alu_a=r, alu_b=divisor, alu_control=sub.
  - If c=1 or r>=divisor (local unsigned compare): hi<=alu_result and lo<={lo[XLEN-2:0],1}.
  - Otherwise: hi<=r and lo<={lo[XLEN-2:0],0}.
- Iteration count:
  - cnt increments each MUL/DIV cycle.
  - After cnt==XLEN-1 the next state is FIXUP (signed op, feature enabled) or DONE.
- Divide by zero (DIVU/DIV with src_b==0, detected at start):
  - Skip DIV and go directly to DONE.
  - lo=all ones; hi=src_a (the unsigned dividend as presented).
- DONE: done=1 for exactly one cycle; hi/lo hold until the next accepted start or reset. Next state is IDLE unless start is accepted.
- alu_req=1 only in MUL/DIV. Elsewhere alu_a=alu_b=0 and alu_control=add.
- busy=1 in MUL, DIV and FIXUP. busy=0 in IDLE and DONE.
- Latency (start sampled at cycle 0):
  - Cycles 1..32 iterate; done at cycle 33 for unsigned ops, cycle 34 for signed ops.
  - Divide by zero: done at cycle 1.

Optional Feature:
- Macro: MDU_SIGNED_EN.
- Defined:
  - op[1]=1 selects signed operation.
  - Operands are converted to magnitudes at start; result signs are recorded.
  - FIXUP (one cycle, always entered for signed ops) negates the 64-bit product if the signs differ. For division, lo is negated if the signs differ, and hi takes the sign of the dividend.
  - INT_MIN/-1 gives lo=0x80000000, hi=0.
- Undefined: op[1] is ignored, every op is unsigned, and the FIXUP state and its logic are absent.

Decomposition:
- Package mdu_pkg holds:
  - the op encoding enum;
  - the state enum;
  - the ALU control constants ALU_ADD=3'b010 and ALU_SUB=3'b110.
- The block is a single module with no sub-module; the iteration datapath is small enough to live inline.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done at cycle 33; hi=0xFFFFFFFE, lo=0x00000001; alu_req=1 for exactly 32 cycles.
- DIVU 100/7 -> done at cycle 33; lo=14, hi=2; alu_control=3'b110 throughout DIV.
- DIVU 0x1234/0 -> done at cycle 1; lo=0xFFFFFFFF, hi=0x00001234; busy never asserted.
- Second start pulsed at cycle 10 of a MULTU 3x5 -> ignored; done once at cycle 33 with lo=15, hi=0. Then a start in the DONE cycle is accepted.
- reset_n low at cycle 15 of a DIVU -> outputs reset immediately, no done pulse; a new MULTU 2x2 then gives lo=4.
- MDU_SIGNED_EN: MULT -3x5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1 at cycle 34. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
